// File: rtl/fft_ctrl_pkg.sv
// Shared types and elaboration helpers for the FFT frame sequencer.
// Provides the sequencer state encoding and log2 helpers used to size counters.
package fft_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Index counters need at least one bit even for degenerate sizes.
  function automatic int index_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fft_seq_fifo.sv
// Synchronous first-word-fall-through FIFO buffering samples ahead of the SDF chain.
// pop_data always shows the oldest entry; count reports occupancy from 0 to DEPTH.
module fft_seq_fifo
  import fft_ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Buffers upstream samples and launches unbroken N-sample bursts into an SDF FFT chain,
// then tags the chain output with index/first/last. Define FFT_SEQ_STATS_EN for frame counters.
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N          = 128,
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_enable,
  input  logic                      cfg_clr_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_re,
  input  logic [WIDTH-1:0]          in_im,
  output logic                      sdf_di_en,
  output logic                      sdf_on,
  output logic [WIDTH-1:0]          sdf_di_re,
  output logic [WIDTH-1:0]          sdf_di_im,
  input  logic                      sdf_do_en,
  output logic                      out_valid,
  output logic [index_width(N)-1:0] out_index,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err_frame
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [31:0]               stat_frames_in,
  output logic [31:0]               stat_frames_out
`endif
);

  localparam int IDX_W = index_width(N);
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   burst_cnt;
  logic [IDX_W-1:0]   burst_cnt_next;
  logic               pop;
  logic               push;
  logic               rdy_q;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic [2*WIDTH-1:0] fifo_data;
  logic [IDX_W-1:0]   idx_cnt;
  logic               frame_err;

  // in_ready stays low through reset and rises on the first clock afterwards.
  assign in_ready = rdy_q && !fifo_full;
  assign push     = in_valid && in_ready;

  fft_seq_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_re, in_im}),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
      rdy_q     <= 1'b1;
    end
  end

  // A burst only starts with a full frame buffered, so popping every BURST cycle never underflows.
  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable && (fifo_count >= N_CNT)) begin
          state_next     = BURST;
          burst_cnt_next = '0;
        end
      end
      BURST: begin
        pop = 1'b1;
        if (burst_cnt == LAST_IDX) begin
          burst_cnt_next = '0;
          if (!(cfg_enable && (fifo_count > N_CNT))) state_next = IDLE;
        end else begin
          burst_cnt_next = burst_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdf_di_en <= 1'b0;
      sdf_di_re <= '0;
      sdf_di_im <= '0;
    end else begin
      sdf_di_en <= pop;
      if (pop) {sdf_di_re, sdf_di_im} <= fifo_data;
      else     {sdf_di_re, sdf_di_im} <= '0;
    end
  end

  assign sdf_on = (state == BURST) || sdf_di_en;

  // idx_cnt is the index the next do_en sample will carry; a nonzero value with do_en low is a short frame.
  assign frame_err = !sdf_do_en && (idx_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      idx_cnt   <= '0;
      err_frame <= 1'b0;
    end else begin
      out_valid <= sdf_do_en;
      out_index <= sdf_do_en ? idx_cnt : '0;
      out_first <= sdf_do_en && (idx_cnt == '0);
      out_last  <= sdf_do_en && (idx_cnt == LAST_IDX);
      if (sdf_do_en) idx_cnt <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + 1'b1;
      else           idx_cnt <= '0;
      if (frame_err)        err_frame <= 1'b1;
      else if (cfg_clr_err) err_frame <= 1'b0;
    end
  end

  assign busy = (state != IDLE) || sdf_di_en || out_valid || (idx_cnt != '0);

`ifdef FFT_SEQ_STATS_EN
  logic frame_launch;

  // Counts both IDLE->BURST starts and back-to-back restarts at the end of a frame.
  assign frame_launch = (state_next == BURST) && ((state == IDLE) || (burst_cnt == LAST_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_in  <= '0;
      stat_frames_out <= '0;
    end else begin
      if (frame_launch) stat_frames_in  <= stat_frames_in + 32'd1;
      if (out_last)     stat_frames_out <= stat_frames_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: pushed samples are queued and checked as sdf_di_en emits them.
// Stat-counter checks are compiled in only when FFT_SEQ_STATS_EN is defined.
module tb_fft_frame_sequencer;

  localparam int N     = 128;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;

  logic             clk;
  logic             rst_n;
  logic             cfg_enable;
  logic             cfg_clr_err;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             sdf_di_en;
  logic             sdf_on;
  logic [WIDTH-1:0] sdf_di_re;
  logic [WIDTH-1:0] sdf_di_im;
  logic             sdf_do_en;
  logic             out_valid;
  logic [6:0]       out_index;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic             err_frame;
`ifdef FFT_SEQ_STATS_EN
  logic [31:0]      stat_frames_in;
  logic [31:0]      stat_frames_out;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cur_run     = 0;
  int last_run    = 0;
  int runs_done   = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  fft_frame_sequencer #(
    .N          (N),
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_enable  (cfg_enable),
    .cfg_clr_err (cfg_clr_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .sdf_di_en   (sdf_di_en),
    .sdf_on      (sdf_on),
    .sdf_di_re   (sdf_di_re),
    .sdf_di_im   (sdf_di_im),
    .sdf_do_en   (sdf_do_en),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .out_first   (out_first),
    .out_last    (out_last),
    .busy        (busy),
    .err_frame   (err_frame)
`ifdef FFT_SEQ_STATS_EN
    ,
    .stat_frames_in  (stat_frames_in),
    .stat_frames_out (stat_frames_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock step; every emitted SDF sample is popped from the scoreboard and compared.
  task automatic tick();
    logic [2*WIDTH-1:0] exp_word;
    @(posedge clk);
    #1;
    if (rst_n && sdf_di_en) begin
      cur_run++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sdf_data: got %h, expected no sample", {sdf_di_re, sdf_di_im});
      end else begin
        exp_word = exp_q.pop_front();
        if ({sdf_di_re, sdf_di_im} !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL sdf_data: got %h, expected %h", {sdf_di_re, sdf_di_im}, exp_word);
        end
      end
    end else if (cur_run != 0) begin
      last_run  = cur_run;
      runs_done++;
      cur_run   = 0;
    end
  endtask

  task automatic push_samples(input int n);
    int pushed = 0;
    int budget = 0;
    while (pushed < n && budget < 4 * n + 10) begin
      in_valid = 1'b1;
      in_re    = WIDTH'($urandom);
      in_im    = WIDTH'($urandom);
      if (in_ready) begin
        exp_q.push_back({in_re, in_im});
        pushed++;
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;
    if (pushed < n) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push_timeout: pushed %0d, expected %0d", pushed, n);
    end
  endtask

  task automatic wait_runs(input int target, input int budget);
    int c = 0;
    while (runs_done < target && c < budget) begin
      tick();
      c++;
    end
    if (runs_done < target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL run_timeout: runs %0d, expected %0d", runs_done, target);
    end
  endtask

  task automatic wait_burst_cycle(input int cycle);
    int c = 0;
    while (cur_run < cycle && c < 3 * N) begin
      tick();
      c++;
    end
    if (cur_run < cycle) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL burst_start_timeout: run %0d, expected %0d", cur_run, cycle);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    cfg_enable  = 1'b0;
    cfg_clr_err = 1'b0;
    in_valid    = 1'b0;
    sdf_do_en   = 1'b0;
    #1;
    exp_q.delete();
    cur_run = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    cfg_enable  = 1'b0;
    cfg_clr_err = 1'b0;
    in_valid    = 1'b0;
    in_re       = '0;
    in_im       = '0;
    sdf_do_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, sdf_di_en, sdf_on, sdf_di_re, sdf_di_im, out_valid, out_index,
         out_first, out_last, busy, err_frame} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: ready=%b di_en=%b on=%b ov=%b idx=%0d busy=%b err=%b, expected all 0",
               in_ready, sdf_di_en, sdf_on, out_valid, out_index, busy, err_frame);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if ({stat_frames_in, stat_frames_out} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stats: in=%0d out=%0d, expected 0", stat_frames_in, stat_frames_out);
    end
`endif
    rst_n = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_single_frame();
    int base;
    do_reset();
    base = runs_done;
    push_samples(N);
    repeat (5) tick();
    vectors++;
    if (sdf_di_en !== 1'b0 || busy !== 1'b0 || runs_done != base) begin
      miscompares++;
      $display("[TB] FAIL idle_before_enable: di_en=%b busy=%b runs=%0d, expected 0 0 %0d",
               sdf_di_en, busy, runs_done, base);
    end
    cfg_enable = 1'b1;
    wait_runs(base + 1, 3 * N);
    vectors++;
    if (last_run != N) begin
      miscompares++;
      $display("[TB] FAIL single_run_len: got %0d, expected %0d", last_run, N);
    end
    vectors++;
    if (sdf_on !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_done: on=%b busy=%b left=%0d, expected 0 0 0", sdf_on, busy, exp_q.size());
    end
    cfg_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = runs_done;
    push_samples(2 * N);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_in_ready: got %b, expected 0", in_ready);
    end
    cfg_enable = 1'b1;
    wait_runs(base + 1, 5 * N);
    vectors++;
    if (last_run != 2 * N) begin
      miscompares++;
      $display("[TB] FAIL b2b_run_len: got %0d, expected %0d", last_run, 2 * N);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (stat_frames_in !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL stat_frames_in: got %0d, expected 2", stat_frames_in);
    end
`endif
    cfg_enable = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_drain: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_threshold();
    int base;
    do_reset();
    base = runs_done;
    cfg_enable = 1'b1;
    push_samples(N - 1);
    repeat (4) tick();
    vectors++;
    if (sdf_di_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL no_launch_below_n: di_en=%b busy=%b, expected 0 0", sdf_di_en, busy);
    end
    push_samples(1);
    tick();
    vectors++;
    if (sdf_on !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL launch_at_n: on=%b busy=%b, expected 1 1", sdf_on, busy);
    end
    wait_runs(base + 1, 3 * N);
    vectors++;
    if (last_run != N) begin
      miscompares++;
      $display("[TB] FAIL threshold_run_len: got %0d, expected %0d", last_run, N);
    end
    cfg_enable = 1'b0;
  endtask

  task automatic test_stop_midburst();
    int base;
    do_reset();
    base = runs_done;
    push_samples(2 * N);
    cfg_enable = 1'b1;
    wait_burst_cycle(10);
    cfg_enable = 1'b0;
    wait_runs(base + 1, 3 * N);
    vectors++;
    if (last_run != N) begin
      miscompares++;
      $display("[TB] FAIL stop_run_len: got %0d, expected %0d", last_run, N);
    end
    repeat (10) tick();
    vectors++;
    if (runs_done != base + 1 || sdf_di_en !== 1'b0 || busy !== 1'b0 || exp_q.size() != N) begin
      miscompares++;
      $display("[TB] FAIL no_relaunch: runs=%0d di_en=%b busy=%b left=%0d, expected %0d 0 0 %0d",
               runs_done, sdf_di_en, busy, exp_q.size(), base + 1, N);
    end
    cfg_enable = 1'b1;
    wait_runs(base + 2, 3 * N);
    vectors++;
    if (last_run != N) begin
      miscompares++;
      $display("[TB] FAIL resume_run_len: got %0d, expected %0d", last_run, N);
    end
    cfg_enable = 1'b0;
  endtask

  task automatic test_output_tagging();
    logic [10:0] exp_tag;
    do_reset();
    sdf_do_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      exp_tag = {1'b1, 7'(i), (i == 0), (i == N - 1), 1'b1};
      vectors++;
      if ({out_valid, out_index, out_first, out_last, busy} !== exp_tag) begin
        miscompares++;
        $display("[TB] FAIL tag_%0d: v/idx/first/last/busy got %b, expected %b", i,
                 {out_valid, out_index, out_first, out_last, busy}, exp_tag);
      end
    end
    sdf_do_en = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || err_frame !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_frame_end: valid=%b err=%b, expected 0 0", out_valid, err_frame);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (stat_frames_out !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL stat_frames_out: got %0d, expected 1", stat_frames_out);
    end
`endif
    sdf_do_en = 1'b1;
    repeat (50) tick();
    sdf_do_en = 1'b0;
    tick();
    vectors++;
    if (err_frame !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL short_frame_err: got %b, expected 1", err_frame);
    end
    cfg_clr_err = 1'b1;
    tick();
    cfg_clr_err = 1'b0;
    vectors++;
    if (err_frame !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_clear: got %b, expected 0", err_frame);
    end
    sdf_do_en = 1'b1;
    repeat (5) tick();
    sdf_do_en   = 1'b0;
    cfg_clr_err = 1'b1;
    tick();
    cfg_clr_err = 1'b0;
    vectors++;
    if (err_frame !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_beats_clear: got %b, expected 1", err_frame);
    end
    sdf_do_en = 1'b1;
    tick();
    vectors++;
    if ({out_valid, out_index, out_first} !== {1'b1, 7'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL restart_index: v/idx/first got %b, expected %b",
               {out_valid, out_index, out_first}, {1'b1, 7'd0, 1'b1});
    end
    sdf_do_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_midburst();
    int base;
    do_reset();
    push_samples(2 * N);
    cfg_enable = 1'b1;
    wait_burst_cycle(20);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sdf_di_en, sdf_on, in_ready, busy, out_valid, sdf_di_re, sdf_di_im} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_outputs: di_en=%b on=%b ready=%b busy=%b data=%h, expected all 0",
               sdf_di_en, sdf_on, in_ready, busy, {sdf_di_re, sdf_di_im});
    end
    exp_q.delete();
    cur_run = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = runs_done;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_midreset: got %b, expected 1", in_ready);
    end
    push_samples(N - 1);
    repeat (4) tick();
    vectors++;
    if (sdf_di_en !== 1'b0 || busy !== 1'b0 || runs_done != base) begin
      miscompares++;
      $display("[TB] FAIL fifo_empty_after_reset: di_en=%b busy=%b runs=%0d, expected 0 0 %0d",
               sdf_di_en, busy, runs_done, base);
    end
    push_samples(1);
    wait_runs(base + 1, 3 * N);
    vectors++;
    if (last_run != N || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_run: len=%0d left=%0d, expected %0d 0", last_run, exp_q.size(), N);
    end
    cfg_enable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_threshold();
    test_stop_midburst();
    test_output_tagging();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
